// File: rtl/button_events.sv
// Multi-channel button conditioner: synchroniser, glitch-rejecting debounce FSM, press/release pulses.
// Optional long-press pulse compiled in with `define BUTTON_EVENTS_LONGPRESS_EN.
module button_events #(
  parameter int CH         = 2,
  parameter int DEB_BITS   = 16,
  parameter int LONG_BITS  = 24,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sw_in,
  output logic [CH-1:0] level,
  output logic [CH-1:0] press,
  output logic [CH-1:0] rel,
  output logic [CH-1:0] long_press
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_1, S_PRESSED, S_WAIT_0} state_t;

  localparam logic [DEB_BITS-1:0] DEB_ONE = {{(DEB_BITS-1){1'b0}}, 1'b1};

  logic [CH-1:0] raw;
  assign raw = ACTIVE_LOW ? ~sw_in : sw_in;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic                sync1_q, s_q;
      state_t              state_q, state_d;
      logic [DEB_BITS-1:0] cnt_q, cnt_d;
      logic                level_q, level_d;
      logic                press_q, press_d;
      logic                rel_q, rel_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q <= 1'b0;
          s_q     <= 1'b0;
          state_q <= S_IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
        end else begin
          sync1_q <= raw[gi];
          s_q     <= sync1_q;
          state_q <= state_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          press_q <= press_d;
          rel_q   <= rel_d;
        end
      end

      // The terminal compare always leaves the wait state, so cnt never wraps.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
          S_IDLE: begin
            if (s_q) begin
              state_d = S_WAIT_1;
              cnt_d   = '0;
            end
          end
          S_WAIT_1: begin
            if (!s_q) begin
              state_d = S_IDLE;
            end else if (cnt_q == '1) begin
              state_d = S_PRESSED;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + DEB_ONE;
            end
          end
          S_PRESSED: begin
            if (!s_q) begin
              state_d = S_WAIT_0;
              cnt_d   = '0;
            end
          end
          S_WAIT_0: begin
            if (s_q) begin
              state_d = S_PRESSED;
            end else if (cnt_q == '1) begin
              state_d = S_IDLE;
              level_d = 1'b0;
              rel_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + DEB_ONE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end

      assign level[gi] = level_q;
      assign press[gi] = press_q;
      assign rel[gi]   = rel_q;

`ifdef BUTTON_EVENTS_LONGPRESS_EN
      localparam logic [LONG_BITS-1:0] LONG_ONE  = {{(LONG_BITS-1){1'b0}}, 1'b1};
      localparam logic [LONG_BITS-1:0] LONG_LAST = {{(LONG_BITS-1){1'b1}}, 1'b0};

      logic [LONG_BITS-1:0] lcnt_q, lcnt_d;
      logic                 long_q, long_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          lcnt_q <= '0;
          long_q <= 1'b0;
        end else begin
          lcnt_q <= lcnt_d;
          long_q <= long_d;
        end
      end

      // Keeps counting through release bounces; saturation gives one pulse per press.
      always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (state_q == S_PRESSED || state_q == S_WAIT_0) begin
          if (lcnt_q != '1) begin
            lcnt_d = lcnt_q + LONG_ONE;
            long_d = (lcnt_q == LONG_LAST);
          end
        end else begin
          lcnt_d = '0;
        end
      end

      assign long_press[gi] = long_q;
`else
      assign long_press[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule
